// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared sizes and state type for the MLP result path
//
// Purpose: constants shared between the MLP control FSM and the result
//          streamer, plus the streamer state encoding.
// Ports:   none (package).
// Config:  none here; the streamer's optional overrun flag is controlled by
//          MLP_STREAM_OVERRUN_EN in rtl/mlp_result_streamer.sv.

package mlp_pkg;

   // Entries in the activation (X) memory and its address width.
   localparam int MlpNumElems   = 256;
   localparam int MlpXAddrWidth = 8;

   typedef enum logic [1:0] {
      Idle  = 2'd0,
      Drain = 2'd1,
      Flush = 2'd2
   } stream_state_t;

endpackage

// File: rtl/mlp_result_streamer_if.sv
// rtl/mlp_result_streamer_if.sv - X-memory read port and result stream bundle
//
// Purpose: groups the X-memory read port and the outgoing valid/ready stream.
// Signals:
//   mem_ren    streamer -> memory  read enable
//   mem_addr   streamer -> memory  read address
//   mem_rdata  memory -> streamer  read data, one cycle after mem_ren
//   out_valid  streamer -> sink    beat valid
//   out_ready  sink -> streamer    sink ready
//   out_data   streamer -> sink    beat data
//   out_last   streamer -> sink    final beat of a result
// Modports: master (streamer side), slave (memory + sink side).

interface mlp_result_streamer_if
   import mlp_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int AddrWidth = MlpXAddrWidth
);

   logic                 mem_ren;
   logic [AddrWidth-1:0] mem_addr;
   logic [DataWidth-1:0] mem_rdata;

   logic                 out_valid;
   logic                 out_ready;
   logic [DataWidth-1:0] out_data;
   logic                 out_last;

   modport master (
      output mem_ren,
      output mem_addr,
      input  mem_rdata,
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  mem_ren,
      input  mem_addr,
      output mem_rdata,
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/mlp_result_streamer_fifo2.sv
// rtl/mlp_result_streamer_fifo2.sv - 2-entry synchronous FIFO for the result streamer
//
// Purpose: holds up to two {last, data} beats between the X-memory read port
//          and the output stream.
// Ports:
//   clk_i   in   clock, rising edge
//   rst_ni  in   asynchronous active-low reset
//   push    in   write wdata (accepted when not full, or when full and popping)
//   pop     in   drop the head entry (ignored when empty)
//   wdata   in   Width bits
//   rdata   out  head entry, Width bits
//   full    out  two entries held
//   empty   out  no entries held
//   count   out  entries held (0..2)

module fifo2 #(
   parameter int Width = 9
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count_q != 2'd0);
   // A push into a full FIFO is legal in the same cycle as a pop: the freed
   // slot is the one the write pointer already points at.
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign count = count_q;

endmodule

// File: rtl/mlp_result_streamer.sv
// rtl/mlp_result_streamer.sv - drains the X memory as a valid/ready stream per result
//
// Purpose: on a result_valid_i pulse, reads all NumElems X-memory entries in
//          address order and streams them out with a last flag. A 2-entry
//          FIFO covers the one-cycle read latency so the stream runs gap-free
//          at one beat per cycle and stalls cleanly under back-pressure.
// Ports:
//   clk_i           in   clock, rising edge
//   rst_ni          in   asynchronous active-low reset
//   result_valid_i  in   1-cycle pulse: X memory holds a finished result
//   busy_o          out  streaming in progress (Drain or Flush)
//   overrun_o       out  sticky: a pulse arrived while busy (option only)
//   bus             master modport of mlp_result_streamer_if
// Config:  MLP_STREAM_OVERRUN_EN builds the sticky overrun flag; without it
//          overrun_o is tied low.

module mlp_result_streamer
   import mlp_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int NumElems  = MlpNumElems,
   parameter int AddrWidth = MlpXAddrWidth
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   result_valid_i,
   output logic                   busy_o,
   output logic                   overrun_o,
   mlp_result_streamer_if.master  bus
);

   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumElems - 1);

   stream_state_t        state_q;
   stream_state_t        state_d;

   logic [AddrWidth-1:0] rd_cnt_q;
   logic                 inflight_q;       // a read was issued last cycle
   logic                 inflight_last_q;  // ...and it was for the final element

   logic                 issue;
   logic                 final_issue;
   logic [2:0]           occ_after;

   logic [DataWidth:0]   fifo_wdata;
   logic [DataWidth:0]   fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [1:0]           fifo_count;

   logic                 pop;
   logic                 last_hs;

   // ------------------------------------------------------------------
   // Output side: the FIFO head is the current beat.
   // ------------------------------------------------------------------
   assign pop     = !fifo_empty && bus.out_ready;
   assign last_hs = pop && fifo_rdata[DataWidth];

   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = fifo_empty ? '0 : fifo_rdata[DataWidth-1:0];
   assign bus.out_last  = !fifo_empty && fifo_rdata[DataWidth];

   // Entries the buffer will have to hold once this cycle's pop is taken
   // into account: stored beats plus the read whose data arrives now.
   assign occ_after = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      issue       = 1'b0;
      final_issue = 1'b0;
      unique case (state_q)
         Idle: begin
            if (result_valid_i) begin
               state_d = Drain;
            end
         end
         Drain: begin
            if (occ_after < 3'd2) begin
               issue = 1'b1;
               if (rd_cnt_q == LastAddr) begin
                  final_issue = 1'b1;
                  state_d     = Flush;
               end
            end
         end
         Flush: begin
            // The buffer is empty once the last beat leaves, so a new pulse
            // landing on that same handshake can start the next drain at once.
            if (last_hs) begin
               state_d = result_valid_i ? Drain : Idle;
            end
         end
         default: begin
            state_d = Idle;
         end
      endcase
   end

   assign busy_o       = (state_q != Idle);
   assign bus.mem_ren  = issue;
   assign bus.mem_addr = issue ? rd_cnt_q : '0;

   // ------------------------------------------------------------------
   // Read counter and in-flight tracking
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_cnt_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         if (issue) begin
            rd_cnt_q <= final_issue ? '0 : rd_cnt_q + AddrWidth'(1);
         end
         inflight_q      <= issue;
         inflight_last_q <= final_issue;
      end
   end

   // Returned data is always pushed; the issue rule guarantees room for it.
   assign fifo_wdata = {inflight_last_q, bus.mem_rdata};

   fifo2 #(
      .Width (DataWidth + 1)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (inflight_q),
      .pop    (pop),
      .wdata  (fifo_wdata),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   no_push_into_full : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(inflight_q && fifo_full && !pop)
   );

   // ------------------------------------------------------------------
   // Optional overrun flag
   // ------------------------------------------------------------------
`ifdef MLP_STREAM_OVERRUN_EN
   logic overrun_q;
   logic ignored_pulse;

   // A pulse accepted on the final handshake is not an overrun.
   assign ignored_pulse = result_valid_i && busy_o &&
                          !((state_q == Flush) && (state_d == Drain));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overrun_q <= 1'b0;
      end else if (ignored_pulse) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun_o = overrun_q;
`else
   assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_result_streamer.sv
// tb/tb_mlp_result_streamer.sv - self-checking bench for mlp_result_streamer
//
// Purpose: drives result pulses and sink back-pressure, models the X memory
//          as data=addr, and checks every cycle against a stream-level model.
// Config:  honours MLP_STREAM_OVERRUN_EN for the expected overrun_o value.

module tb_mlp_result_streamer;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int N  = 256;

`ifdef MLP_STREAM_OVERRUN_EN
   localparam bit OverrunEn = 1'b1;
`else
   localparam bit OverrunEn = 1'b0;
`endif

   typedef struct {
      int mode;       // 0: ready always 1, 1: random ready, 2: ready low in [lo,hi]
      int lo;
      int hi;
      int dup_beat;   // second pulse while beat dup_beat is pending, -1 none
      int exp_last;   // cycle of last handshake relative to pulse, -1 unchecked
      int exp_reads;  // reads issued by end of cycle hi, -1 unchecked
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic result_valid;
   logic busy;
   logic overrun;
   logic [DW-1:0] mem_q = '0;

   mlp_result_streamer_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

   mlp_result_streamer #(
      .DataWidth (DW),
      .NumElems  (N),
      .AddrWidth (AW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .result_valid_i (result_valid),
      .busy_o         (busy),
      .overrun_o      (overrun),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   // X memory: one-cycle read latency, contents equal to the address.
   always @(posedge clk) begin
      if (bus.mem_ren) mem_q <= DW'(bus.mem_addr);
   end
   assign bus.mem_rdata = mem_q;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Stream-level model state
   bit m_active;
   bit m_ovr;
   int m_idx;       // beats accepted in the current stream
   int m_rd;        // reads issued in the current stream
   int m_start;     // cycle the current stream's pulse was accepted
   int m_last_cyc;
   int n_last;

   vec_t tbl [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit ready_for(input vec_t v, input int t);
      if (v.mode == 1) return 1'($urandom_range(0, 1));
      if (v.mode == 2) return !(t >= v.lo && t <= v.hi);
      return 1'b1;
   endfunction

   task automatic check_reset_outputs();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_out_last",  bus.out_last,  0);
      check("rst_mem_ren",   bus.mem_ren,   0);
      check("rst_mem_addr",  bus.mem_addr,  0);
      check("rst_busy",      busy,          0);
      check("rst_overrun",   overrun,       0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      result_valid = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_active = 0;
      m_ovr = 0;
      m_idx = 0;
      m_rd = 0;
   endtask

   // One clock cycle: drive inputs, sample outputs, check, advance the model.
   task automatic do_cycle(input bit p, input bit r);
      bit hs;
      bit last_hs;
      bit was_active;
      @(negedge clk);
      cyc++;
      result_valid = p;
      bus.out_ready = r;
      #1;
      hs = bus.out_valid && r;
      was_active = m_active;
      check("busy", busy, m_active);
      check("overrun", overrun, OverrunEn ? m_ovr : 1'b0);
      check("out_valid", bus.out_valid, m_active && (cyc >= m_start + 3));
      if (bus.out_valid && m_active) begin
         check("out_data", bus.out_data, m_idx % 256);
         check("out_last", bus.out_last, m_idx == N - 1);
      end
      if (bus.mem_ren) begin
         check("read_allowed", m_active && (m_rd < N), 1);
         check("mem_addr", bus.mem_addr, m_rd);
         check("read_ahead", (m_rd - m_idx - int'(hs)) < 2, 1);
         m_rd++;
      end
      last_hs = 0;
      if (hs && bus.out_last) n_last++;
      if (hs && m_active) begin
         if (m_idx == N - 1) begin
            last_hs = 1;
            m_active = 0;
            m_last_cyc = cyc;
         end
         m_idx++;
      end
      if (p) begin
         if (!was_active || last_hs) begin
            m_active = 1;
            m_idx = 0;
            m_rd = 0;
            m_start = cyc;
         end else begin
            m_ovr = 1;
         end
      end
   endtask

   task automatic run_row(input vec_t v);
      int base;
      bit dup_done;
      bit p;
      do_cycle(0, 1);
      do_cycle(1, ready_for(v, 0));
      base = cyc;
      dup_done = 0;
      for (int t = 1; t < 3000 && m_active; t++) begin
         p = 0;
         if (v.dup_beat >= 0 && !dup_done && m_idx == v.dup_beat) begin
            p = 1;
            dup_done = 1;
         end
         do_cycle(p, ready_for(v, t));
         if (v.exp_reads >= 0 && t == v.hi) check("reads_at_stall_end", m_rd, v.exp_reads);
      end
      check("stream_done", m_active, 0);
      if (v.exp_last >= 0) check("last_cycle", m_last_cyc - base, v.exp_last);
      repeat (3) do_cycle(0, 1);
   endtask

   initial begin
      rst_n = 1'b1;
      result_valid = 1'b0;
      bus.out_ready = 1'b0;
      n_last = 0;

      tbl[0] = '{mode: 0, lo: 0, hi: 0,  dup_beat: -1, exp_last: 258, exp_reads: -1};
      tbl[1] = '{mode: 2, lo: 3, hi: 20, dup_beat: -1, exp_last: 276, exp_reads: 2};
      tbl[2] = '{mode: 1, lo: 0, hi: 0,  dup_beat: -1, exp_last: -1,  exp_reads: -1};
      tbl[3] = '{mode: 0, lo: 0, hi: 0,  dup_beat: 50, exp_last: 258, exp_reads: -1};

      #3;
      for (int i = 0; i < 4; i++) begin
         apply_reset();
         run_row(tbl[i]);
      end

      // Reset in the middle of a drain, then a fresh stream from address 0.
      apply_reset();
      do_cycle(0, 1);
      do_cycle(1, 1);
      for (int t = 0; t < 400 && m_idx < 100; t++) do_cycle(0, 1);
      check("reached_beat_100", m_idx, 100);
      #2;
      apply_reset();
      run_row(tbl[0]);

      // Pulse on the final handshake, then a pulse the cycle busy drops.
      apply_reset();
      n_last = 0;
      do_cycle(0, 1);
      do_cycle(1, 1);
      for (int t = 1; t < 1200; t++) begin
         do_cycle((t == 258) || (t == 517), 1);
         if (t > 517 && !m_active) break;
      end
      check("b2b_last_beats", n_last, 3);
      check("b2b_stream_done", m_active, 0);
      repeat (3) do_cycle(0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
